// File: rtl/vc_flit_skid_reg_pkg.sv
// Shared defaults and the stored-entry layout for the VC flit skid register.
package vc_flit_skid_reg_pkg;
  localparam int FLIT_W     = 32;
  localparam int DEF_VC_W   = 2;
  localparam int DEF_NUM_VC = 4;
  localparam logic [FLIT_W-1:0] DEF_IDLE_FLIT = 32'h6000_0000;

  typedef struct packed {
    logic                valid;
    logic [DEF_VC_W-1:0] vc;
    logic [FLIT_W-1:0]   flit;
  } flit_entry_t;
endpackage

// File: rtl/flit_entry_reg.sv
// One stored flit slot: async clear, load, and invalidate back to the idle pattern.
module flit_entry_reg
  import vc_flit_skid_reg_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int VC_W   = DEF_VC_W,
  parameter logic [DATA_W-1:0] IDLE = DATA_W'(DEF_IDLE_FLIT)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic              inv,
  input  logic [VC_W-1:0]   d_vc,
  input  logic [DATA_W-1:0] d_flit,
  output logic              valid,
  output logic [VC_W-1:0]   vc,
  output logic [DATA_W-1:0] flit
);
  logic              valid_q, valid_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [DATA_W-1:0] flit_q, flit_d;

  // Invalidate outranks load so a flush always leaves the slot idle.
  always_comb begin
    valid_d = valid_q;
    vc_d    = vc_q;
    flit_d  = flit_q;
    if (inv) begin
      valid_d = 1'b0;
      vc_d    = '0;
      flit_d  = IDLE;
    end else if (load) begin
      valid_d = 1'b1;
      vc_d    = d_vc;
      flit_d  = d_flit;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      valid_q <= 1'b0;
      vc_q    <= '0;
      flit_q  <= IDLE;
    end else begin
      valid_q <= valid_d;
      vc_q    <= vc_d;
      flit_q  <= flit_d;
    end
  end

  assign valid = valid_q;
  assign vc    = vc_q;
  assign flit  = flit_q;
endmodule

// File: rtl/vc_flit_skid_reg.sv
// Flit pipeline register with 2-entry skid: registered in_ready, full throughput, VC tag carried along.
module vc_flit_skid_reg
  import vc_flit_skid_reg_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int VC_W   = DEF_VC_W,
  parameter int NUM_VC = DEF_NUM_VC,
  parameter logic [DATA_W-1:0] IDLE_FLIT = DATA_W'(DEF_IDLE_FLIT)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  input  logic [DATA_W-1:0] in_flit,
  output logic              in_ready,
  output logic              out_valid,
  output logic [VC_W-1:0]   out_vc,
  output logic [DATA_W-1:0] out_flit,
  input  logic              out_ready,
  output logic [1:0]        occ,
  output logic [NUM_VC-1:0] vc_busy
);
  logic              main_v, skid_v;
  logic [VC_W-1:0]   main_vc, skid_vc;
  logic [DATA_W-1:0] main_flit, skid_flit;
  logic              push, pop;
  logic              main_load, main_inv, skid_load, skid_inv;
  logic [VC_W-1:0]   main_d_vc;
  logic [DATA_W-1:0] main_d_flit;

  assign in_ready = ~skid_v & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = main_v & out_ready;

  // Main refills from skid when skid is occupied, otherwise straight from the input.
  always_comb begin
    main_load   = 1'b0;
    main_inv    = flush;
    skid_load   = 1'b0;
    skid_inv    = flush;
    main_d_vc   = skid_v ? skid_vc   : in_vc;
    main_d_flit = skid_v ? skid_flit : in_flit;
    if (!flush) begin
      if (skid_v) begin
        main_load = pop;
        skid_inv  = pop;
      end else begin
        main_load = push & (~main_v | pop);
        main_inv  = pop & ~push;
        skid_load = push & main_v & ~pop;
      end
    end
  end

  flit_entry_reg #(.DATA_W(DATA_W), .VC_W(VC_W), .IDLE(IDLE_FLIT)) u_main (
    .clk(clk), .clr_n(clr_n), .load(main_load), .inv(main_inv),
    .d_vc(main_d_vc), .d_flit(main_d_flit),
    .valid(main_v), .vc(main_vc), .flit(main_flit)
  );

  flit_entry_reg #(.DATA_W(DATA_W), .VC_W(VC_W), .IDLE(IDLE_FLIT)) u_skid (
    .clk(clk), .clr_n(clr_n), .load(skid_load), .inv(skid_inv),
    .d_vc(in_vc), .d_flit(in_flit),
    .valid(skid_v), .vc(skid_vc), .flit(skid_flit)
  );

  assign out_valid = main_v;
  assign out_flit  = main_v ? main_flit : IDLE_FLIT;
  assign out_vc    = main_v ? main_vc : '0;
  assign occ       = {1'b0, main_v} + {1'b0, skid_v};

  for (genvar v = 0; v < NUM_VC; v++) begin : g_busy
    assign vc_busy[v] = (main_v && main_vc == VC_W'(v)) || (skid_v && skid_vc == VC_W'(v));
  end
endmodule

// File: tb/tb_vc_flit_skid_reg.sv
// Directed + random bench for vc_flit_skid_reg against a 2-deep FIFO queue model.
module tb_vc_flit_skid_reg;
  import vc_flit_skid_reg_pkg::*;

  localparam logic [31:0] IDLE = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        clr_n, flush, in_valid, out_ready;
  logic [1:0]  in_vc, out_vc, occ;
  logic [31:0] in_flit, out_flit;
  logic        in_ready, out_valid;
  logic [3:0]  vc_busy;

  flit_entry_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int hs    = 0;

  always #5 clk = ~clk;

  vc_flit_skid_reg dut (
    .clk(clk), .clr_n(clr_n), .flush(flush),
    .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit), .in_ready(in_ready),
    .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit), .out_ready(out_ready),
    .occ(occ), .vc_busy(vc_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [3:0] busy;
    busy = '0;
    foreach (q[i]) busy[q[i].vc] = 1'b1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".out_flit"},  out_flit, (q.size() != 0) ? q[0].flit : IDLE);
    chk({tag, ".out_vc"},    32'(out_vc), (q.size() != 0) ? 32'(q[0].vc) : 32'd0);
    chk({tag, ".occ"},       32'(occ), 32'(q.size()));
    chk({tag, ".vc_busy"},   32'(vc_busy), 32'(busy));
    chk({tag, ".skid_impl_main"}, 32'(dut.u_skid.valid_q & ~dut.u_main.valid_q), 32'd0);
  endtask

  // One clock: drive at negedge, check in_ready, update queue model at posedge, check after.
  task automatic step(input string tag, input logic iv, input logic [1:0] ivc,
                      input logic [31:0] iflit, input logic ordy, input logic fl);
    bit do_push, do_pop;
    @(negedge clk);
    in_valid  = iv;
    in_vc     = iv ? ivc : 2'bxx;
    in_flit   = iv ? iflit : 32'hxxxx_xxxx;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2 && !fl));
    do_push = iv && q.size() < 2 && !fl;
    do_pop  = q.size() != 0 && ordy;
    if (out_valid && out_ready) hs++;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{valid: 1'b1, vc: ivc, flit: iflit});
    end
    check_state(tag);
  endtask

  // Reset asserted mid-cycle, away from any clock edge, with a live input flit.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in_vc    = 2'($urandom);
    in_flit  = $urandom;
    clr_n    = 1'b0;
    #1;
    q.delete();
    check_state("midrst");
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_vc = 2'd1; in_flit = $urandom;
    #3;
    check_state("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;

    // single flit
    step("single", 1'b1, 2'd2, 32'h1234_5678, 1'b1, 1'b0);
    chk("single.flit", out_flit, 32'h1234_5678);
    chk("single.busy", 32'(vc_busy), 32'h4);
    step("single_drain", 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    chk("single.idle", out_flit, IDLE);

    // back-pressure: A, B stored, C held off, then drained in order
    step("bp_a", 1'b1, 2'd0, 32'hAAAA_0000, 1'b0, 1'b0);
    step("bp_b", 1'b1, 2'd3, 32'hBBBB_0003, 1'b0, 1'b0);
    chk("bp.occ", 32'(occ), 32'd2);
    chk("bp.busy", 32'(vc_busy), 32'h9);
    step("bp_c_held", 1'b1, 2'd1, 32'hCCCC_0001, 1'b0, 1'b0);
    step("bp_rel1", 1'b1, 2'd1, 32'hCCCC_0001, 1'b1, 1'b0);
    chk("bp.b_out", out_flit, 32'hBBBB_0003);
    step("bp_rel2", 1'b1, 2'd1, 32'hCCCC_0001, 1'b1, 1'b0);
    chk("bp.c_out", out_flit, 32'hCCCC_0001);
    step("bp_rel3", 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    chk("bp.empty", 32'(occ), 32'd0);

    // streaming: 100 flits through in 101 cycles
    hs = 0;
    for (int i = 0; i < 100; i++) step("stream", 1'b1, 2'(i), 32'hF000_0000 | 32'(i), 1'b1, 1'b0);
    step("stream_end", 1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
    chk("stream.handshakes", 32'(hs), 32'd100);

    // flush with a full buffer and a flit on the input
    step("fl_a", 1'b1, 2'd0, 32'h0000_00A1, 1'b0, 1'b0);
    step("fl_b", 1'b1, 2'd1, 32'h0000_00B2, 1'b0, 1'b0);
    step("flush", 1'b1, 2'd2, 32'h0000_00C3, 1'b0, 1'b1);
    chk("flush.occ", 32'(occ), 32'd0);
    chk("flush.flit", out_flit, IDLE);
    chk("flush.busy", 32'(vc_busy), 32'd0);

    // random valid/ready/flush with occasional mid-stream reset
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) mid_reset();
      step("rand", 1'($urandom_range(0, 2) != 0), 2'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vc_flit_skid_reg.md
Name: vc_flit_skid_reg

Overview:
- Parametrised flit pipeline register with a 2-entry skid buffer and valid/ready handshake on both sides.
- Carries a VC tag alongside each flit.
- Drives the IDLE_FLIT pattern whenever it holds no valid flit.
- Sits between the input buffer / VC allocator stage and the crossbar. It breaks the ready timing path without losing throughput.

Parameters:
- DATA_W, 32, flit width in bits.
- VC_W, 2, width of the VC tag.
- NUM_VC, 4, number of VCs; must equal 2**VC_W.
- IDLE_FLIT, 32'h6000_0000, value driven on out_flit when out_valid=0; DATA_W bits wide.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all stored flits.
- in_valid  in  1  upstream flit valid.
- in_vc  in  VC_W  VC tag of the input flit.
- in_flit  in  DATA_W  input flit.
- in_ready  out  1  stage can accept a flit.
- out_valid  out  1  output flit valid.
- out_vc  out  VC_W  VC tag of the output flit.
- out_flit  out  DATA_W  output flit; IDLE_FLIT when not valid.
- out_ready  in  1  downstream accepts.
- occ  out  2  number of stored flits (0..2).
- vc_busy  out  NUM_VC  bit v set iff a stored flit carries VC v.

Behaviour:
- One clock; reset is asynchronous and active-low (clr_n), the clock is clk.
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds valid, vc and flit.
- Reset values: both entries invalid; stored flit fields = IDLE_FLIT; stored vc = 0. Outputs during reset: out_valid=0, out_flit=IDLE_FLIT, out_vc=0, occ=0, vc_busy=0, in_ready=1.
- in_ready = ~skid_valid & ~flush. It depends only on registered state and flush, never on out_ready.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- out_valid = main_valid. out_flit = main_valid ? main_flit : IDLE_FLIT. out_vc = main_vc, or 0 when invalid.
- Latency: a flit pushed at edge N is on the output after edge N when the main entry is empty or popped at edge N.
- Next-state rules per edge (occ, push, pop):
  - occ=0, push: main <= in.
  - occ=1, push & pop: main <= in.
  - occ=1, push & ~pop: skid <= in; main holds.
  - occ=1, ~push & pop: main invalid; outputs return to IDLE_FLIT.
  - occ=2 (in_ready=0), pop: main <= skid; skid invalid.
  - occ=2, ~pop: hold.
- Order is strict FIFO across VCs; no reordering.
- Full throughput: with in_valid=out_ready=1 continuously, one flit per cycle.
- flush=1: both entries invalidated at the next edge. A flit presented that cycle is not accepted (in_ready=0). A pop handshake in the flush cycle still counts downstream; the flush wins for storage.
- Invalidated entries reload their flit field with IDLE_FLIT, so stale data never appears.
- vc_busy: the OR of one-hot(main_vc) when main valid and one-hot(skid_vc) when skid valid. Both entries on the same VC set a single bit.
- occ = main_valid + skid_valid. skid_valid implies main_valid (invariant; assert in bench).
- Reset asserted mid-operation: immediate return to reset values regardless of clk. Deassertion must be synchronised externally.
- in_flit/in_vc are sampled only on push. X on them while in_ready=0 or in_valid=0 must not propagate.

Decomposition:
- Shared package holds: FLIT_W default, VC_W/NUM_VC defaults, IDLE_FLIT constant (32'h6000_0000), and a flit-entry typedef {valid, vc, flit}.
- One natural sub-module: flit_entry_reg. It is a single async-clear entry register with load/invalidate controls and loads IDLE_FLIT on invalidate. It is instantiated twice (main, skid).

Test Plan:
- Reset: clr_n=0 with in_valid=1 and random data -> out_valid=0, out_flit=32'h6000_0000, occ=0, vc_busy=4'b0000, in_ready=1. Outputs change without a clock edge.
- Single flit: push 32'h1234_5678 on vc=2 with out_ready=1 -> next cycle out_valid=1, out_flit=32'h1234_5678, out_vc=2, vc_busy=4'b0100. The following cycle out_flit=32'h6000_0000.
- Back-pressure: out_ready=0, push A (vc0) then B (vc3) -> occ=2, in_ready=0, vc_busy=4'b1001, C held off. Raise out_ready -> A, B, C emerge in order with no drop and no duplicate.
- Streaming: 100 flits, in_valid=out_ready=1 -> 100 output handshakes in 101 cycles, data in order.
- Flush: occ=2 plus flush=1 with in_valid=1 -> next cycle occ=0, out_flit=32'h6000_0000, vc_busy=0, input flit not accepted.
- Random valid/ready and reset mid-stream (compare against a scoreboard) -> FIFO order, occ<=2, skid_valid implies main_valid, IDLE_FLIT whenever out_valid=0.
